// File: rtl/bist_march_gen_pkg.sv
// Shared definitions for the March C- BIST engine: the element table, op and state encodings.
// The element table is written as small functions so the sequencer can decode it combinationally.
package bist_march_gen_pkg;

   typedef enum logic [1:0] {W0, W1, R0, R1} op_e;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

   localparam int DEFAULT_RD_LAT = 3;
   localparam logic [2:0] LAST_ELEM = 3'd5;

   // March C-: E0 B(w0) E1 U(r0,w1) E2 U(r1,w0) E3 D(r0,w1) E4 D(r1,w0) E5 B(r0)
   function automatic logic elem_down(input logic [2:0] e);
      return (e == 3'd3) || (e == 3'd4);
   endfunction

   function automatic logic elem_single(input logic [2:0] e);
      return (e == 3'd0) || (e == 3'd5);
   endfunction

   function automatic op_e elem_op(input logic [2:0] e, input logic opi);
      op_e op;
      case (e)
         3'd0:    op = W0;
         3'd1:    op = opi ? W1 : R0;
         3'd2:    op = opi ? W0 : R1;
         3'd3:    op = opi ? W1 : R0;
         3'd4:    op = opi ? W0 : R1;
         default: op = R0;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/bist_cmp_pipe.sv
// Read-compare delay line: carries {valid, addr, expected} for RD_LAT cycles so each entry
// emerges exactly when the memory returns the matching read data, then compares.
module bist_cmp_pipe
   import bist_march_gen_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int RD_LAT = DEFAULT_RD_LAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_exp,
   input  logic [DATA_W-1:0] rdata,
   output logic              mismatch,
   output logic [ADDR_W-1:0] mis_addr
);

   logic [RD_LAT-1:0] vld;
   logic [ADDR_W-1:0] addr_q [RD_LAT];
   logic [DATA_W-1:0] exp_q  [RD_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            addr_q[i] <= '0;
            exp_q[i]  <= '0;
         end
      end else begin
         vld[0]    <= in_valid;
         addr_q[0] <= in_addr;
         exp_q[0]  <= in_exp;
         for (int i = 1; i < RD_LAT; i++) begin
            vld[i]    <= vld[i-1];
            addr_q[i] <= addr_q[i-1];
            exp_q[i]  <= exp_q[i-1];
         end
      end
   end

   assign mismatch = vld[RD_LAT-1] && (rdata != exp_q[RD_LAT-1]);
   assign mis_addr = addr_q[RD_LAT-1];

endmodule

// File: rtl/bist_march_gen.sv
// March C- BIST sequencer driving the memory-controller strobe stage in BISR mode,
// with a delayed read-compare path that reports failing addresses to the repair logic.
module bist_march_gen
   import bist_march_gen_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int RD_LAT = DEFAULT_RD_LAT
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   output logic              BUSY,
   output logic              DONE,
   output logic              PASS,
   output logic              BISR_EN,
   output logic [ADDR_W-1:0] ADDR,
   output logic              CSB,
   output logic              WEB,
   output logic              OEB,
   output logic [DATA_W-1:0] WDATA,
   input  logic [DATA_W-1:0] RDATA,
   output logic              FAIL_VALID,
   output logic [ADDR_W-1:0] FAIL_ADDR,
   output logic [7:0]        FAIL_COUNT
);

   localparam int DCW = $clog2(RD_LAT + 1);

   state_e            state, state_nxt;
   logic [2:0]        elem, elem_nx;
   logic              opi;
   logic [ADDR_W-1:0] acnt, term;
   logic [DCW-1:0]    drain_cnt;
   logic [DATA_W-1:0] rd_exp, pattern;
   op_e               cur_op;
   logic              op_last, last_op, start_run, is_write;
   logic              mismatch;
   logic [ADDR_W-1:0] mis_addr;

   always_comb begin
      cur_op    = elem_op(elem, opi);
      is_write  = (cur_op == W0) || (cur_op == W1);
      pattern   = {DATA_W{(cur_op == W1) || (cur_op == R1)}};
      term      = elem_down(elem) ? '0 : '1;
      op_last   = elem_single(elem) || opi;
      elem_nx   = elem + 3'd1;
      last_op   = (elem == LAST_ELEM) && (acnt == {ADDR_W{1'b1}});
      start_run = START && ((state == ST_IDLE) || (state == ST_DONE));
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: if (START) state_nxt = ST_RUN;
         ST_RUN:           if (last_op) state_nxt = ST_DRAIN;
         ST_DRAIN:         if (drain_cnt == DCW'(RD_LAT)) state_nxt = ST_DONE;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   // Status flags follow the next state so they are registered yet line up with the state change.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_IDLE;
         elem      <= '0;
         opi       <= 1'b0;
         acnt      <= '0;
         drain_cnt <= '0;
         BUSY      <= 1'b0;
         BISR_EN   <= 1'b0;
         DONE      <= 1'b0;
         ADDR      <= '0;
         CSB       <= 1'b1;
         WEB       <= 1'b1;
         OEB       <= 1'b1;
         WDATA     <= '0;
         rd_exp    <= '0;
      end else begin
         state   <= state_nxt;
         BUSY    <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
         BISR_EN <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
         DONE    <= (state_nxt == ST_DONE);
         CSB     <= 1'b1;
         WEB     <= 1'b1;
         OEB     <= 1'b1;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (START) begin
                  elem <= '0;
                  opi  <= 1'b0;
                  acnt <= '0;
               end
            end
            ST_RUN: begin
               CSB       <= 1'b0;
               ADDR      <= acnt;
               drain_cnt <= '0;
               if (is_write) begin
                  WEB   <= 1'b0;
                  WDATA <= pattern;
               end else begin
                  OEB    <= 1'b0;
                  rd_exp <= pattern;
               end
               // Step op, then address, then element; a fresh element restarts at its own start address.
               if (!op_last) begin
                  opi <= 1'b1;
               end else begin
                  opi <= 1'b0;
                  if (acnt == term) begin
                     elem <= elem_nx;
                     acnt <= elem_down(elem_nx) ? '1 : '0;
                  end else begin
                     acnt <= elem_down(elem) ? acnt - 1'b1 : acnt + 1'b1;
                  end
               end
            end
            ST_DRAIN: drain_cnt <= drain_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   bist_cmp_pipe #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_cmp (
      .clk      (CLK),
      .rst      (RST),
      .in_valid (!CSB && !OEB),
      .in_addr  (ADDR),
      .in_exp   (rd_exp),
      .rdata    (RDATA),
      .mismatch (mismatch),
      .mis_addr (mis_addr)
   );

   // A mismatch landing on the DONE edge itself must still clear PASS.
   always_ff @(posedge CLK) begin
      if (RST) begin
         FAIL_VALID <= 1'b0;
         FAIL_ADDR  <= '0;
         FAIL_COUNT <= '0;
         PASS       <= 1'b0;
      end else begin
         FAIL_VALID <= mismatch;
         if (mismatch) FAIL_ADDR <= mis_addr;
         if (start_run) begin
            FAIL_COUNT <= '0;
            PASS       <= 1'b0;
         end else begin
            if (mismatch && (FAIL_COUNT != 8'hFF)) FAIL_COUNT <= FAIL_COUNT + 8'd1;
            if ((state == ST_DRAIN) && (state_nxt == ST_DONE))
               PASS <= (FAIL_COUNT == 8'd0) && !mismatch;
         end
      end
   end

endmodule

// File: tb/tb_bist_march_gen.sv
// Self-checking bench: a 16-word instance checked cycle by cycle against a March C- op list and
// faulty-memory model, plus a 256-word instance whose memory returns wrong data on every read.
module tb_bist_march_gen;

   localparam int RD_LAT = 3;
   localparam int WORDS  = 16;
   localparam int NOPS   = 10 * WORDS;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        RST, start4, start8;
   logic        busy4, done4, pass4, bisr4, csb4, web4, oeb4, fv4;
   logic [3:0]  addr4, fa4;
   logic [31:0] wdata4, rdata4;
   logic [7:0]  fc4;
   logic        busy8, done8, pass8, bisr8, csb8, web8, oeb8, fv8;
   logic [7:0]  addr8, fa8, fc8;
   logic [31:0] wdata8, rdata8;

   assign rdata8 = 32'h5A5A_5A5A;

   bist_march_gen #(.ADDR_W(4), .DATA_W(32), .RD_LAT(RD_LAT)) u_dut4 (
      .CLK(CLK), .RST(RST), .START(start4), .BUSY(busy4), .DONE(done4), .PASS(pass4),
      .BISR_EN(bisr4), .ADDR(addr4), .CSB(csb4), .WEB(web4), .OEB(oeb4), .WDATA(wdata4),
      .RDATA(rdata4), .FAIL_VALID(fv4), .FAIL_ADDR(fa4), .FAIL_COUNT(fc4));

   bist_march_gen #(.ADDR_W(8), .DATA_W(32), .RD_LAT(RD_LAT)) u_dut8 (
      .CLK(CLK), .RST(RST), .START(start8), .BUSY(busy8), .DONE(done8), .PASS(pass8),
      .BISR_EN(bisr8), .ADDR(addr8), .CSB(csb8), .WEB(web8), .OEB(oeb8), .WDATA(wdata8),
      .RDATA(rdata8), .FAIL_VALID(fv8), .FAIL_ADDR(fa8), .FAIL_COUNT(fc8));

   int n_checks = 0;
   int n_fail   = 0;
   int fault_mode = 0;

   typedef struct {
      logic [3:0]  addr;
      bit          wr;
      logic [31:0] data;
   } op_t;

   op_t ops[$];
   int  fail_ops[$];

   int E_NOPS [6]    = '{1, 2, 2, 2, 2, 1};
   int E_CODE [6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 0}};
   bit E_DOWN [6]    = '{0, 0, 0, 1, 1, 0};

   // Memory seen by the 16-word instance; fault 1 is a whole-word stuck-at-0 at address 5.
   logic [31:0] mem4 [WORDS];
   logic [31:0] dl   [RD_LAT+1];
   always @(negedge CLK) begin
      logic [31:0] v;
      v = '0;
      if (!csb4 && !web4) mem4[addr4] = (fault_mode == 1 && addr4 == 4'd5) ? '0 : wdata4;
      if (!csb4 && !oeb4) v = mem4[addr4];
      for (int i = RD_LAT; i > 0; i--) dl[i] = dl[i-1];
      dl[0]  = v;
      rdata4 = dl[RD_LAT];
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void buildModel(input int fault);
      logic [31:0] mm [WORDS];
      ops.delete();
      fail_ops.delete();
      foreach (mm[i]) mm[i] = '0;
      for (int e = 0; e < 6; e++) begin
         for (int k = 0; k < WORDS; k++) begin
            int a;
            a = E_DOWN[e] ? WORDS - 1 - k : k;
            for (int o = 0; o < E_NOPS[e]; o++) begin
               op_t op;
               int  cd;
               cd      = E_CODE[e][o];
               op.addr = 4'(a);
               op.wr   = (cd < 2);
               op.data = (cd % 2 == 1) ? 32'hFFFF_FFFF : 32'h0;
               if (op.wr) mm[a] = (fault == 1 && a == 5) ? 32'h0 : op.data;
               else if (mm[a] != op.data) fail_ops.push_back(ops.size());
               ops.push_back(op);
            end
         end
      end
   endfunction

   task automatic applyStimulus();
      @(negedge CLK);
      start4 = 1'b1;
      @(posedge CLK);
      #1;
      start4 = 1'b0;
   endtask

   // c counts edges after the START edge; op i is visible at c=i+1, its failure pulse at c=i+RD_LAT+2.
   task automatic runMarch(input int fault, input int midc, input int abortc, input bit doStart);
      logic [31:0] lastw;
      int nf;
      lastw = '0;
      fault_mode = fault;
      buildModel(fault);
      nf = fail_ops.size();
      if (doStart) applyStimulus();
      for (int c = 0; c <= NOPS + RD_LAT + 2; c++) begin
         bit expfv;
         int fidx;
         if (c > 0) begin
            @(posedge CLK);
            #1;
         end
         start4 = 1'b0;
         if (c >= 1 && c <= NOPS) begin
            op_t op;
            op = ops[c-1];
            if (op.wr) lastw = op.data;
            checkOutput("op", {addr4, csb4, web4, oeb4, wdata4},
                        {op.addr, 1'b0, !op.wr, op.wr, lastw});
         end else begin
            checkOutput("idle_strobes", {csb4, web4, oeb4}, 3'b111);
         end
         checkOutput("busy_bisr_done", {busy4, bisr4, done4},
                     {c <= NOPS + RD_LAT, c <= NOPS + RD_LAT, c >= NOPS + RD_LAT + 1});
         expfv = 1'b0;
         fidx  = 0;
         foreach (fail_ops[j]) if (fail_ops[j] + RD_LAT + 2 == c) begin expfv = 1'b1; fidx = fail_ops[j]; end
         checkOutput("fail_valid", fv4, expfv);
         if (expfv) checkOutput("fail_addr", fa4, ops[fidx].addr);
         if (c == midc) start4 = 1'b1;
         if (c == abortc) begin
            RST = 1'b1;
            @(posedge CLK);
            #1;
            RST = 1'b0;
            checkOutput("rst_flags", {busy4, bisr4, done4, pass4, fv4}, 5'b0);
            checkOutput("rst_strobes", {csb4, web4, oeb4}, 3'b111);
            checkOutput("rst_addr_wdata", {addr4, wdata4}, 36'h0);
            checkOutput("rst_fail_regs", {fa4, fc4}, 12'h0);
            for (int k = 0; k < 2 * RD_LAT + 2; k++) begin
               @(posedge CLK);
               #1;
               checkOutput("post_rst_fail_valid", {fv4, fc4}, 9'h0);
            end
            return;
         end
      end
      checkOutput("fail_count", fc4, (nf > 255) ? 255 : nf);
      checkOutput("pass", pass4, nf == 0);
   endtask

   typedef struct {
      int fault;
      int midc;
      bit exp_pass;
      int exp_count;
   } vec_t;

   initial begin
      vec_t vecs[3];
      int   pulses;
      int   cyc;
      vecs[0] = '{0, -1, 1'b1, 0};
      vecs[1] = '{1, -1, 1'b0, 2};
      vecs[2] = '{0, 40 + int'($urandom_range(0, 60)), 1'b1, 0};

      RST = 1'b1;
      start4 = 1'b0;
      start8 = 1'b0;
      foreach (mem4[i]) mem4[i] = 32'(i) ^ $urandom;
      repeat (3) @(posedge CLK);
      #1;
      checkOutput("reset_flags", {busy4, bisr4, done4, pass4, fv4}, 5'b0);
      checkOutput("reset_strobes", {csb4, web4, oeb4}, 3'b111);
      checkOutput("reset_regs", {addr4, wdata4, fa4, fc4}, 48'h0);
      RST = 1'b0;

      for (int v = 0; v < 3; v++) begin
         runMarch(vecs[v].fault, vecs[v].midc, -1, 1'b1);
         checkOutput("tbl_pass", pass4, vecs[v].exp_pass);
         checkOutput("tbl_count", fc4, vecs[v].exp_count);
      end

      // Restart from DONE after a failing run must clear the count and drop DONE on that edge.
      runMarch(1, -1, -1, 1'b1);
      fault_mode = 0;
      applyStimulus();
      checkOutput("restart_clear", {done4, pass4, busy4, fc4}, {1'b0, 1'b0, 1'b1, 8'h0});
      runMarch(0, -1, -1, 1'b0);

      // Reset while the E2 r1 of address 5 is still inside the compare pipe.
      runMarch(1, -1, 60, 1'b1);

      // 256 words, every read wrong: 1280 mismatches, count saturates.
      @(negedge CLK);
      start8 = 1'b1;
      @(posedge CLK);
      #1;
      start8 = 1'b0;
      pulses = 0;
      cyc = 0;
      while (!done8 && cyc < 4000) begin
         @(posedge CLK);
         #1;
         cyc++;
         if (fv8) pulses++;
      end
      checkOutput("done8_in_time", done8, 1'b1);
      checkOutput("done8_edge", cyc, 10 * 256 + RD_LAT + 1);
      checkOutput("pulses8", pulses, 5 * 256);
      checkOutput("fail_count8", fc8, 8'd255);
      checkOutput("pass8", pass8, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
